// File: rtl/vt_command_handler_if.sv
// Byte-stream and screen-update bundle for the VT command handler.
// Carries the received-byte handshake (data/valid/ready, auto_wrap), the
// character-buffer write port, the cursor update port, the top-row address and bell.
interface vt_command_handler_if #(
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
);
  logic [7:0]           data;
  logic                 valid;
  logic                 ready;
  logic                 auto_wrap;
  logic [7:0]           char_out;
  logic [ADDR_BITS-1:0] char_addr;
  logic                 char_wen;
  logic [COL_BITS-1:0]  cursor_x;
  logic [ROW_BITS-1:0]  cursor_y;
  logic                 cursor_wen;
  logic [ADDR_BITS-1:0] first_char;
  logic                 first_char_wen;
  logic                 bell;

  // Byte source / screen consumer side.
  modport master (
    output data, valid, auto_wrap,
    input  ready, char_out, char_addr, char_wen, cursor_x, cursor_y, cursor_wen,
           first_char, first_char_wen, bell
  );

  // Command handler side.
  modport slave (
    input  data, valid, auto_wrap,
    output ready, char_out, char_addr, char_wen, cursor_x, cursor_y, cursor_wen,
           first_char, first_char_wen, bell
  );
endinterface

// File: rtl/vt_command_handler.sv
// VT52-style byte interpreter driving a circular character buffer, cursor and scroll origin.
// Latency: every effect of a byte accepted at an edge is registered and visible right after it.
// Backpressure: ready drops only while a multi-cycle erase streams spaces, one write per cycle.
// Ports: clk, clr (async, active-high); bus = slave side of vt_command_handler_if.
module vt_command_handler #(
  parameter int ROWS      = 24,
  parameter int COLS      = 80,
  parameter int TAB_WIDTH = 8,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
) (
  input logic                 clk,
  input logic                 clr,
  vt_command_handler_if.slave bus
);

  localparam int SIZE = ROWS * COLS;
  localparam int AW1  = ADDR_BITS + 1;
  localparam logic [AW1-1:0]       SIZE_W = AW1'(SIZE);
  localparam logic [ADDR_BITS-1:0] COLS_A = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] A_LAST = ADDR_BITS'(SIZE - 1);
  localparam logic [COL_BITS-1:0]  X_MAX  = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0]  Y_MAX  = ROW_BITS'(ROWS - 1);

  typedef enum logic [2:0] {S_CHAR, S_ESC, S_ROW, S_COL, S_ERASE} state_t;

  state_t               r_state;
  logic [COL_BITS-1:0]  r_cx;
  logic [ROW_BITS-1:0]  r_cy;
  logic [ROW_BITS-1:0]  r_row;
  logic [ADDR_BITS-1:0] r_first;
  logic [7:0]           r_char_out;
  logic [ADDR_BITS-1:0] r_char_addr;
  logic                 r_char_wen;
  logic                 r_cursor_wen;
  logic                 r_first_wen;
  logic                 r_bell;
  logic                 r_ready;
  logic [ADDR_BITS-1:0] r_erase_addr;
  logic [AW1-1:0]       r_erase_cnt;   // writes still to issue; 0 means leave ERASE

  // (a + b) mod SIZE for a, b < SIZE
  function automatic logic [ADDR_BITS-1:0] add_mod(input logic [ADDR_BITS-1:0] a,
                                                   input logic [ADDR_BITS-1:0] b);
    logic [AW1-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= SIZE_W) s = s - SIZE_W;
    return s[ADDR_BITS-1:0];
  endfunction

  // (a - b) mod SIZE for a, b < SIZE
  function automatic logic [ADDR_BITS-1:0] sub_mod(input logic [ADDR_BITS-1:0] a,
                                                   input logic [ADDR_BITS-1:0] b);
    logic [AW1-1:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + SIZE_W - {1'b0, b};
    return s[ADDR_BITS-1:0];
  endfunction

  logic [ADDR_BITS-1:0] w_offset;    // cursor offset from the top-left cell
  logic [ADDR_BITS-1:0] w_cur_addr;
  logic [COL_BITS:0]    w_tab;
  logic [COL_BITS-1:0]  w_tab_x;
  logic                 w_print;
  logic                 w_do_lf;
  logic                 w_row_ok;
  logic                 w_col_ok;

  assign w_offset   = ADDR_BITS'(r_cy) * COLS_A + ADDR_BITS'(r_cx);
  assign w_cur_addr = add_mod(r_first, w_offset);
  // Next tab stop: round x up past the current stop, then clamp to the last column.
  assign w_tab      = {1'b0, r_cx | COL_BITS'(TAB_WIDTH - 1)} + (COL_BITS + 1)'(1);
  assign w_tab_x    = (w_tab > {1'b0, X_MAX}) ? X_MAX : w_tab[COL_BITS-1:0];
  assign w_print    = (bus.data >= 8'h20) && (bus.data <= 8'h7E);
  assign w_row_ok   = (bus.data >= 8'h20) && (bus.data < 8'(32 + ROWS));
  assign w_col_ok   = (bus.data >= 8'h20) && (bus.data < 8'(32 + COLS));
  // Linefeed comes from LF itself or from a printable wrapping off the last column.
  assign w_do_lf    = (r_state == S_CHAR) && bus.valid &&
                      ((bus.data == 8'h0A) || (w_print && (r_cx == X_MAX) && bus.auto_wrap));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= S_CHAR;
      r_cx         <= '0;
      r_cy         <= '0;
      r_row        <= '0;
      r_first      <= '0;
      r_char_out   <= '0;
      r_char_addr  <= '0;
      r_char_wen   <= 1'b0;
      r_cursor_wen <= 1'b0;
      r_first_wen  <= 1'b0;
      r_bell       <= 1'b0;
      r_ready      <= 1'b1;
      r_erase_addr <= '0;
      r_erase_cnt  <= '0;
    end else begin
      r_char_wen   <= 1'b0;
      r_cursor_wen <= 1'b0;
      r_first_wen  <= 1'b0;
      r_bell       <= 1'b0;
      case (r_state)
        S_CHAR: if (bus.valid) begin
          if (w_print) begin
            r_char_wen  <= 1'b1;
            r_char_addr <= w_cur_addr;
            r_char_out  <= bus.data;
            if (r_cx != X_MAX) begin
              r_cx <= r_cx + COL_BITS'(1); r_cursor_wen <= 1'b1;
            end else if (bus.auto_wrap) begin
              r_cx <= '0; r_cursor_wen <= 1'b1;
            end
          end else begin
            case (bus.data)
              8'h08: if (r_cx != '0) begin r_cx <= r_cx - COL_BITS'(1); r_cursor_wen <= 1'b1; end
              8'h0D: if (r_cx != '0) begin r_cx <= '0; r_cursor_wen <= 1'b1; end
              8'h09: if (r_cx != X_MAX) begin r_cx <= w_tab_x; r_cursor_wen <= 1'b1; end
              8'h07: r_bell <= 1'b1;
              8'h1B: r_state <= S_ESC;
              default: ;
            endcase
          end
          if (w_do_lf) begin
            if (r_cy != Y_MAX) begin
              r_cy <= r_cy + ROW_BITS'(1); r_cursor_wen <= 1'b1;
            end else begin
              // Scroll: the old top row becomes the new bottom row and is blanked.
              r_first      <= add_mod(r_first, COLS_A);
              r_first_wen  <= 1'b1;
              r_erase_addr <= r_first;
              r_erase_cnt  <= AW1'(COLS);
              r_ready      <= 1'b0;
              r_state      <= S_ERASE;
            end
          end
        end
        S_ESC: if (bus.valid) begin
          r_state <= S_CHAR;
          case (bus.data)
            8'h41: if (r_cy != '0) begin r_cy <= r_cy - ROW_BITS'(1); r_cursor_wen <= 1'b1; end
            8'h42: if (r_cy != Y_MAX) begin r_cy <= r_cy + ROW_BITS'(1); r_cursor_wen <= 1'b1; end
            8'h43: if (r_cx != X_MAX) begin r_cx <= r_cx + COL_BITS'(1); r_cursor_wen <= 1'b1; end
            8'h44: if (r_cx != '0) begin r_cx <= r_cx - COL_BITS'(1); r_cursor_wen <= 1'b1; end
            8'h48: begin r_cx <= '0; r_cy <= '0; r_cursor_wen <= 1'b1; end
            8'h49: if (r_cy != '0) begin
              r_cy <= r_cy - ROW_BITS'(1); r_cursor_wen <= 1'b1;
            end else begin
              // Reverse scroll: a fresh blank row appears above the old top.
              r_first      <= sub_mod(r_first, COLS_A);
              r_first_wen  <= 1'b1;
              r_erase_addr <= sub_mod(r_first, COLS_A);
              r_erase_cnt  <= AW1'(COLS);
              r_ready      <= 1'b0;
              r_state      <= S_ERASE;
            end
            8'h4B: begin
              r_erase_addr <= w_cur_addr;
              r_erase_cnt  <= AW1'(COLS) - AW1'(r_cx);
              r_ready      <= 1'b0;
              r_state      <= S_ERASE;
            end
            8'h4A: begin
              r_erase_addr <= w_cur_addr;
              r_erase_cnt  <= SIZE_W - {1'b0, w_offset};
              r_ready      <= 1'b0;
              r_state      <= S_ERASE;
            end
            8'h45: begin
              r_cx         <= '0;
              r_cy         <= '0;
              r_cursor_wen <= 1'b1;
              r_erase_addr <= r_first;
              r_erase_cnt  <= SIZE_W;
              r_ready      <= 1'b0;
              r_state      <= S_ERASE;
            end
            8'h59: r_state <= S_ROW;
            8'h1B: r_state <= S_ESC;
            default: ;
          endcase
        end
        S_ROW: if (bus.valid) begin
          r_row   <= w_row_ok ? ROW_BITS'(bus.data - 8'h20) : r_cy;
          r_state <= S_COL;
        end
        S_COL: if (bus.valid) begin
          r_cx         <= w_col_ok ? COL_BITS'(bus.data - 8'h20) : X_MAX;
          r_cy         <= r_row;
          r_cursor_wen <= 1'b1;
          r_state      <= S_CHAR;
        end
        S_ERASE: begin
          if (r_erase_cnt != '0) begin
            r_char_wen   <= 1'b1;
            r_char_out   <= 8'h20;
            r_char_addr  <= r_erase_addr;
            r_erase_addr <= (r_erase_addr == A_LAST) ? '0 : r_erase_addr + ADDR_BITS'(1);
            r_erase_cnt  <= r_erase_cnt - AW1'(1);
          end else begin
            r_state <= S_CHAR;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_CHAR;
      endcase
    end
  end

  assign bus.ready          = r_ready;
  assign bus.char_out       = r_char_out;
  assign bus.char_addr      = r_char_addr;
  assign bus.char_wen       = r_char_wen;
  assign bus.cursor_x       = r_cx;
  assign bus.cursor_y       = r_cy;
  assign bus.cursor_wen     = r_cursor_wen;
  assign bus.first_char     = r_first;
  assign bus.first_char_wen = r_first_wen;
  assign bus.bell           = r_bell;

endmodule

// File: tb/tb_vt_command_handler.sv
module tb_vt_command_handler;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  vt_command_handler_if bus ();

  vt_command_handler dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        aw;
    logic        cw;
    logic [10:0] ca;
    logic [7:0]  co;
    logic [6:0]  x;
    logic [4:0]  y;
    logic        xw;
    logic        bl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [7:0] d, input logic aw, input logic cw,
                              input int ca, input logic [7:0] co, input int x, input int y,
                              input logic xw, input logic bl);
    vec_t v;
    v.d = d; v.aw = aw; v.cw = cw; v.ca = 11'(ca); v.co = co;
    v.x = 7'(x); v.y = 5'(y); v.xw = xw; v.bl = bl;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.valid = 1'b0; bus.data = 8'h00; bus.auto_wrap = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.data = b; bus.valid = 1'b1;
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask

  // Follows an erase until ready returns, recording the space writes it sees.
  task automatic collect(input int limit, output int n, output int a0, output int a1,
                         output int bad, output bit timeout);
    int prev;
    n = 0; a0 = -1; a1 = -1; bad = 0; timeout = 1'b1; prev = -1;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (bus.char_wen) begin
        if (bus.char_out !== 8'h20) bad++;
        if (prev >= 0 && int'(bus.char_addr) != (prev + 1) % 1920) bad++;
        if (n == 0) a0 = int'(bus.char_addr);
        prev = int'(bus.char_addr);
        a1 = prev;
        n++;
      end
      if (bus.ready === 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int n, a0, a1, bad, wcnt;
    bit to;

    bus.valid = 1'b0; bus.data = 8'h00; bus.auto_wrap = 1'b0;
    #2 clr = 1'b1;
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_wens", {bus.char_wen, bus.cursor_wen, bus.first_char_wen, bus.bell}, 0);
    chk("rst_cursor", {bus.cursor_x, bus.cursor_y}, 0);
    chk("rst_first", bus.first_char, 0);
    chk("rst_char", {bus.char_out, bus.char_addr}, 0);
    @(negedge clk); clr = 1'b0;

    // d, aw, char_wen, char_addr, char_out, x, y, cursor_wen, bell
    add(8'h41, 0, 1, 0,   8'h41, 1,  0, 1, 0);
    add(8'h42, 0, 1, 1,   8'h42, 2,  0, 1, 0);
    add(8'h08, 0, 0, 0,   8'h00, 1,  0, 1, 0);
    add(8'h0D, 0, 0, 0,   8'h00, 0,  0, 1, 0);
    add(8'h0D, 0, 0, 0,   8'h00, 0,  0, 0, 0);
    add(8'h08, 0, 0, 0,   8'h00, 0,  0, 0, 0);
    add(8'h09, 0, 0, 0,   8'h00, 8,  0, 1, 0);
    add(8'h09, 0, 0, 0,   8'h00, 16, 0, 1, 0);
    add(8'h0A, 0, 0, 0,   8'h00, 16, 1, 1, 0);
    add(8'h43, 0, 1, 96,  8'h43, 17, 1, 1, 0);
    add(8'h07, 0, 0, 0,   8'h00, 17, 1, 0, 1);
    add(8'h01, 0, 0, 0,   8'h00, 17, 1, 0, 0);
    add(8'h1B, 0, 0, 0,   8'h00, 17, 1, 0, 0);
    add(8'h41, 0, 0, 0,   8'h00, 17, 0, 1, 0);
    add(8'h1B, 0, 0, 0,   8'h00, 17, 0, 0, 0);
    add(8'h42, 0, 0, 0,   8'h00, 17, 1, 1, 0);
    add(8'h1B, 0, 0, 0,   8'h00, 17, 1, 0, 0);
    add(8'h43, 0, 0, 0,   8'h00, 18, 1, 1, 0);
    add(8'h1B, 0, 0, 0,   8'h00, 18, 1, 0, 0);
    add(8'h44, 0, 0, 0,   8'h00, 17, 1, 1, 0);
    add(8'h1B, 0, 0, 0,   8'h00, 17, 1, 0, 0);
    add(8'h48, 0, 0, 0,   8'h00, 0,  0, 1, 0);
    add(8'h1B, 0, 0, 0,   8'h00, 0,  0, 0, 0);
    add(8'h1B, 0, 0, 0,   8'h00, 0,  0, 0, 0);
    add(8'h5A, 0, 0, 0,   8'h00, 0,  0, 0, 0);
    add(8'h51, 0, 1, 0,   8'h51, 1,  0, 1, 0);
    add(8'h1B, 0, 0, 0,   8'h00, 1,  0, 0, 0);
    add(8'h59, 0, 0, 0,   8'h00, 1,  0, 0, 0);
    add(8'h25, 0, 0, 0,   8'h00, 1,  0, 0, 0);
    add(8'h2A, 0, 0, 0,   8'h00, 10, 5, 1, 0);
    add(8'h1B, 0, 0, 0,   8'h00, 10, 5, 0, 0);
    add(8'h59, 0, 0, 0,   8'h00, 10, 5, 0, 0);
    add(8'h50, 0, 0, 0,   8'h00, 10, 5, 0, 0);
    add(8'h7F, 0, 0, 0,   8'h00, 79, 5, 1, 0);
    add(8'h58, 0, 1, 479, 8'h58, 79, 5, 0, 0);
    add(8'h0D, 0, 0, 0,   8'h00, 0,  5, 1, 0);
    add(8'h1B, 0, 0, 0,   8'h00, 0,  5, 0, 0);
    add(8'h59, 0, 0, 0,   8'h00, 0,  5, 0, 0);
    add(8'h25, 0, 0, 0,   8'h00, 0,  5, 0, 0);
    add(8'h6D, 0, 0, 0,   8'h00, 77, 5, 1, 0);
    add(8'h09, 0, 0, 0,   8'h00, 79, 5, 1, 0);
    add(8'h09, 0, 0, 0,   8'h00, 79, 5, 0, 0);
    add(8'h57, 1, 1, 479, 8'h57, 0,  6, 1, 0);
    add(8'h0A, 0, 0, 0,   8'h00, 0,  7, 1, 0);
    add(8'h7E, 0, 1, 560, 8'h7E, 1,  7, 1, 0);
    add(8'h7F, 0, 0, 0,   8'h00, 1,  7, 0, 0);
    add(8'h1F, 0, 0, 0,   8'h00, 1,  7, 0, 0);

    foreach (tbl[i]) begin
      bus.auto_wrap = tbl[i].aw;
      send(tbl[i].d);
      chk($sformatf("vec%0d_char_wen", i), bus.char_wen, tbl[i].cw);
      if (tbl[i].cw)
        chk($sformatf("vec%0d_char", i), {bus.char_addr, bus.char_out}, {tbl[i].ca, tbl[i].co});
      chk($sformatf("vec%0d_cursor", i), {bus.cursor_x, bus.cursor_y}, {tbl[i].x, tbl[i].y});
      chk($sformatf("vec%0d_cursor_wen", i), bus.cursor_wen, tbl[i].xw);
      chk($sformatf("vec%0d_bell", i), bus.bell, tbl[i].bl);
      chk($sformatf("vec%0d_ready_fwen", i), {bus.ready, bus.first_char_wen}, 2'b10);
    end

    // Wrap at the bottom-right corner scrolls and blanks the old top row.
    do_reset();
    send(8'h1B); send(8'h59); send(8'h37); send(8'h6F);
    chk("wrap_setup_cursor", {bus.cursor_x, bus.cursor_y}, {7'd79, 5'd23});
    bus.auto_wrap = 1'b1;
    send(8'h5A);
    chk("wrap_char", {bus.char_wen, bus.char_addr, bus.char_out}, {1'b1, 11'd1919, 8'h5A});
    chk("wrap_first", {bus.first_char_wen, bus.first_char}, {1'b1, 11'd80});
    chk("wrap_ready0", bus.ready, 0);
    chk("wrap_cursor", {bus.cursor_wen, bus.cursor_x, bus.cursor_y}, {1'b1, 7'd0, 5'd23});
    // A byte offered during the erase must be ignored.
    bus.data = 8'h51; bus.valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      bus.auto_wrap = i[0];
      @(posedge clk); #1;
      chk($sformatf("wrap_erase%0d", i), {bus.char_wen, bus.char_addr, bus.char_out, bus.ready},
          {1'b1, 11'(i), 8'h20, 1'b0});
    end
    @(posedge clk); #1;
    chk("wrap_done", {bus.char_wen, bus.ready}, 2'b01);
    bus.valid = 1'b0;
    chk("wrap_final", {bus.cursor_x, bus.cursor_y, bus.first_char}, {7'd0, 5'd23, 11'd80});

    // Reverse scroll at the top, then erase to end of screen across the wrap point.
    do_reset();
    send(8'h1B); send(8'h49);
    chk("revscroll_first", {bus.first_char_wen, bus.first_char, bus.ready}, {1'b1, 11'd1840, 1'b0});
    collect(200, n, a0, a1, bad, to);
    chk("revscroll_timeout", to, 0);
    chk("revscroll_writes", n, 80);
    chk("revscroll_range", {a0, a1}, {32'd1840, 32'd1919});
    chk("revscroll_seq", bad, 0);

    send(8'h1B); send(8'h4A);
    chk("eraseJ_ready0", bus.ready, 0);
    collect(2500, n, a0, a1, bad, to);
    chk("eraseJ_timeout", to, 0);
    chk("eraseJ_writes", n, 1920);
    chk("eraseJ_range", {a0, a1}, {32'd1840, 32'd1839});
    chk("eraseJ_seq", bad, 0);
    chk("eraseJ_ready1", bus.ready, 1);

    send(8'h1B); send(8'h59); send(8'h20); send(8'h6B);
    send(8'h1B); send(8'h4B);
    collect(200, n, a0, a1, bad, to);
    chk("eraseK_timeout", to, 0);
    chk("eraseK_writes", n, 5);
    chk("eraseK_range", {a0, a1}, {32'd1915, 32'd1919});

    // Reset in the middle of a full-screen clear aborts it.
    send(8'h1B); send(8'h45);
    chk("clear_home", {bus.cursor_wen, bus.cursor_x, bus.cursor_y, bus.ready}, {1'b1, 12'd0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    chk("clear_10th", {bus.char_wen, bus.char_addr}, {1'b1, 11'd1849});
    clr = 1'b1;
    #1;
    chk("abort_wen", bus.char_wen, 0);
    chk("abort_ready", bus.ready, 1);
    chk("abort_state", {bus.cursor_x, bus.cursor_y, bus.first_char}, 0);
    @(negedge clk); clr = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.char_wen !== 1'b0) wcnt++;
    end
    chk("abort_no_writes", wcnt, 0);
    chk("abort_ready_after", bus.ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
